// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// Registered one-hot grant, bounded locked bursts, owner-only writes.
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ-1:0]       wr_en,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic                   wr_err
);

  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [OW-1:0]   owner_n, ptr, ptr_n;
  logic [OW-1:0]   nxt, base, win;
  logic [HW-1:0]   hold, hold_n;
  logic [WIDTH-1:0] q_n;
  logic            wr_err_n, keep;
  int              idx;

  assign nxt = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
  assign base = (state == GRANT) ? nxt : ptr;
  assign busy = (state == GRANT);
  assign q_bar = ~q;

  // Scan downward so the lowest offset from base wins.
  always_comb begin
    win = base;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % N_REQ;
      if (req[idx]) win = OW'(idx);
    end
  end

  assign keep = req[owner] && lock[owner] &&
                (hold < HW'(HOLD_MAX - 1));

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    hold_n  = hold;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (|req) begin
          state_n = GRANT;
          gnt_n   = N_REQ'(1) << win;
          owner_n = win;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (keep) begin
          hold_n = hold + HW'(1);
        end else begin
          ptr_n = nxt;
          if (|req) begin
            gnt_n   = N_REQ'(1) << win;
            owner_n = win;
            hold_n  = '0;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            hold_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    q_n = q;
    if (|(gnt & wr_en))
      q_n = wdata[int'(owner)*WIDTH +: WIDTH];
    wr_err_n = |(wr_en & ~gnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      hold   <= '0;
      ptr    <= '0;
      q      <= '0;
      wr_err <= 1'b0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      owner  <= owner_n;
      hold   <= hold_n;
      ptr    <= ptr_n;
      q      <= q_n;
      wr_err <= wr_err_n;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus random traffic
// compared against a tenure-level reference model.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;

  logic           clk = 0;
  logic           reset;
  logic [N-1:0]   req, lock, wr_en;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   q, q_bar;
  logic           wr_err;

  int errors = 0;
  int checks = 0;

  int       m_own;
  int       m_len;
  int       m_ptr;
  int       m_q;
  bit       m_err;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_MAX(H)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .wr_en(wr_en), .wdata(wdata), .gnt(gnt), .owner(owner),
    .busy(busy), .q(q), .q_bar(q_bar), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model(input bit rst, input logic [N-1:0] r,
                       input logic [N-1:0] l, input logic [N-1:0] w,
                       input logic [N*W-1:0] wd);
    if (rst) begin
      m_own = -1; m_len = 0; m_ptr = 0; m_q = 0; m_err = 0;
      return;
    end
    m_err = 0;
    for (int j = 0; j < N; j++)
      if (w[j] && j != m_own) m_err = 1;
    if (m_own >= 0 && w[m_own]) m_q = int'(wd[m_own*W +: W]);
    if (m_own < 0) begin
      if (r != 0) begin m_own = rr_pick(r, m_ptr); m_len = 1; end
    end else if (r[m_own] && l[m_own] && m_len < H) begin
      m_len++;
    end else begin
      m_ptr = (m_own + 1) % N;
      if (r != 0) begin m_own = rr_pick(r, m_ptr); m_len = 1; end
      else m_own = -1;
    end
  endtask

  task automatic step(input bit rst, input logic [N-1:0] r,
                      input logic [N-1:0] l, input logic [N-1:0] w,
                      input logic [N*W-1:0] wd);
    logic [N-1:0] eg;
    reset = rst; req = r; lock = l; wr_en = w; wdata = wd;
    @(posedge clk);
    model(rst, r, l, w, wd);
    #1;
    eg = (m_own >= 0) ? N'(1) << m_own : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_own >= 0));
    if (m_own >= 0) chk("owner", 32'(owner), 32'(m_own));
    chk("q", 32'(q), 32'(m_q));
    chk("q_bar", 32'(q_bar), 32'(~m_q & 8'hFF));
    chk("wr_err", 32'(wr_err), 32'(m_err));
    chk("onehot", 32'($countones(gnt) <= 1), 32'(1));
  endtask

  initial begin
    logic [N*W-1:0] wd;
    logic [N-1:0] exp_rot [5];
    exp_rot[0] = 4'b0001; exp_rot[1] = 4'b0010; exp_rot[2] = 4'b0100;
    exp_rot[3] = 4'b1000; exp_rot[4] = 4'b0001;
    reset = 1; req = 0; lock = 0; wr_en = 0; wdata = 0;
    m_own = -1; m_len = 0; m_ptr = 0; m_q = 0; m_err = 0;

    step(1, 0, 0, 0, 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_q", 32'(q), 0);
    step(0, 4'b0001, 0, 0, 0);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_owner", 32'(owner), 0);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b1111, 0, 0, 0);
      chk("t2_rot", 32'(gnt), 32'(exp_rot[i]));
    end

    step(1, 0, 0, 0, 0);
    step(0, 4'b0100, 4'b0100, 0, 0);
    chk("t3_first", 32'(gnt), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0101, 4'b0100, 0, 0);
      chk("t3_hold", 32'(gnt), 32'h4);
    end
    step(0, 4'b0101, 4'b0100, 0, 0);
    chk("t3_next", 32'(gnt), 32'h1);

    step(1, 0, 0, 0, 0);
    step(0, 4'b0010, 0, 0, 0);
    wd = 0; wd[15:8] = 8'hA5;
    step(0, 4'b0010, 0, 4'b0010, wd);
    chk("t4_q", 32'(q), 32'hA5);
    chk("t4_qbar", 32'(q_bar), 32'h5A);
    wd = 0; wd[31:24] = 8'hFF;
    step(0, 4'b0010, 0, 4'b1000, wd);
    chk("t4_keep", 32'(q), 32'hA5);
    chk("t4_err", 32'(wr_err), 1);
    step(0, 4'b0010, 0, 0, 0);
    chk("t4_err_end", 32'(wr_err), 0);

    step(0, 4'b0001, 4'b0001, 0, 0);
    step(0, 4'b0001, 4'b0001, 0, 0);
    step(1, 4'b0001, 4'b0001, 4'b0001, 32'h77);
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_q", 32'(q), 0);
    step(0, 4'b0010, 0, 0, 0);
    chk("t5_regnt", 32'(gnt), 32'h2);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 4'b0001, 4'b0001, 0, 0);
      chk("t6_gnt", 32'(gnt), 32'h1);
    end

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, l, w;
      r = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) != 0) r = r | N'($urandom);
      l = N'($urandom) | N'($urandom);
      w = N'($urandom) & N'($urandom) & N'($urandom);
      step($urandom_range(0, 49) == 0, r, l, w, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
